// File: rtl/ff256_ct_seq_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module  : ff256_ct_seq_ctrl_param
//  Brief   : Parametrised load/drain/done sequencer for the FF(256) cosine-
//            transform MAC datapath, with input stall, abort and continuous mode.
//  Rev     : 1.0  initial release
// ============================================================================
module ff256_ct_seq_ctrl_param #(
  parameter int N_PTS      = 8,
  parameter int PIPE_LAT   = 2,
  parameter int CONTINUOUS = 0,
  localparam int IDX_W     = ($clog2(N_PTS) > 1) ? $clog2(N_PTS) : 1,
  localparam int CNT_MAX   = (N_PTS > PIPE_LAT) ? N_PTS : PIPE_LAT,
  localparam int CNT_W     = ($clog2(CNT_MAX) > 1) ? $clog2(CNT_MAX) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt_cmpt,
  input  logic             abort,
  input  logic             in_vld,
  output logic             load_en,
  output logic             acc_clr,
  output logic [IDX_W-1:0] sample_idx,
  output logic             busy,
  output logic             out_vld,
  output logic             done,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_last_sample = CNT_W'(N_PTS - 1);
  localparam logic [CNT_W-1:0] c_last_drain  = (PIPE_LAT > 0) ? CNT_W'(PIPE_LAT - 1) : '0;
  // With no drain latency the last sample goes straight to DONE.
  localparam state_t c_after_load = (PIPE_LAT > 0) ? S_DRAIN : S_DONE;

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic             r_out_vld;
  logic             w_in_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      // Pulse only on the edge that enters DONE, never while sitting in it.
      r_out_vld <= (w_state_n == S_DONE) && (r_state != S_DONE);
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (abort) begin
      w_state_n = S_IDLE;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_n = '0;
          if (strt_cmpt) begin
            w_state_n = S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_vld) begin
            if (r_cnt == c_last_sample) begin
              w_state_n = c_after_load;
              w_cnt_n   = '0;
            end else begin
              w_cnt_n = r_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == c_last_drain) begin
            w_state_n = S_DONE;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          w_cnt_n = '0;
          if (!strt_cmpt) begin
            w_state_n = S_IDLE;
          end else if (CONTINUOUS != 0) begin
            w_state_n = S_LOAD;
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  assign w_in_load  = (r_state == S_LOAD);
  assign load_en    = w_in_load & in_vld & ~abort;
  assign acc_clr    = load_en & (r_cnt == '0);
  assign sample_idx = w_in_load ? r_cnt[IDX_W-1:0] : '0;
  assign busy       = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign out_vld    = r_out_vld;
  assign done       = (r_state == S_DONE);
  assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ff256_ct_seq_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ff256_ct_seq_ctrl_param
//  Brief   : Bench for three sequencer configurations against a sample-count
//            reference model, plus directed tables and corner sequences.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ff256_ct_seq_ctrl_param;

  logic clk = 1'b0;
  logic rst;
  logic strt_cmpt, abort, in_vld;

  logic       ld0, ac0, bz0, ov0, dn0;
  logic [2:0] ix0;
  logic [1:0] st0;
  logic       ld1, ac1, bz1, ov1, dn1;
  logic [2:0] ix1;
  logic [1:0] st1;
  logic       ld2, ac2, bz2, ov2, dn2;
  logic [3:0] ix2;
  logic [1:0] st2;

  always #5 clk = ~clk;

  ff256_ct_seq_ctrl_param #(.N_PTS(8), .PIPE_LAT(2), .CONTINUOUS(0)) u_dflt (
    .clk(clk), .rst(rst), .strt_cmpt(strt_cmpt), .abort(abort), .in_vld(in_vld),
    .load_en(ld0), .acc_clr(ac0), .sample_idx(ix0), .busy(bz0),
    .out_vld(ov0), .done(dn0), .state_o(st0));

  ff256_ct_seq_ctrl_param #(.N_PTS(8), .PIPE_LAT(2), .CONTINUOUS(1)) u_cont (
    .clk(clk), .rst(rst), .strt_cmpt(strt_cmpt), .abort(abort), .in_vld(in_vld),
    .load_en(ld1), .acc_clr(ac1), .sample_idx(ix1), .busy(bz1),
    .out_vld(ov1), .done(dn1), .state_o(st1));

  ff256_ct_seq_ctrl_param #(.N_PTS(16), .PIPE_LAT(0), .CONTINUOUS(0)) u_n16 (
    .clk(clk), .rst(rst), .strt_cmpt(strt_cmpt), .abort(abort), .in_vld(in_vld),
    .load_en(ld2), .acc_clr(ac2), .sample_idx(ix2), .busy(bz2),
    .out_vld(ov2), .done(dn2), .state_o(st2));

  // Packed view: {load_en, acc_clr, idx[3:0], busy, out_vld, done, state[1:0]}
  logic [10:0] act [3];
  assign act[0] = {ld0, ac0, 1'b0, ix0, bz0, ov0, dn0, st0};
  assign act[1] = {ld1, ac1, 1'b0, ix1, bz1, ov1, dn1, st1};
  assign act[2] = {ld2, ac2, ix2, bz2, ov2, dn2, st2};

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [10:0] smp [3];

  // Reference model: phase plus samples consumed / drain cycles elapsed.
  int NP [3] = '{8, 8, 16};
  int PL [3] = '{2, 2, 0};
  int CT [3] = '{0, 1, 0};
  int m_phase [3];
  int m_taken [3];
  int m_drained [3];
  bit m_pulse [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_phase[k] = 0; m_taken[k] = 0; m_drained[k] = 0; m_pulse[k] = 1'b0;
    end
  endtask

  function automatic logic [10:0] m_exp(int k, logic a, logic v);
    logic ld, ac;
    int   idx;
    ld  = (m_phase[k] == 1) && v && !a;
    ac  = ld && (m_taken[k] == 0);
    idx = (m_phase[k] == 1) ? m_taken[k] : 0;
    return {ld, ac, 4'(idx), (m_phase[k] == 1 || m_phase[k] == 2), m_pulse[k],
            (m_phase[k] == 3), 2'(m_phase[k])};
  endfunction

  task automatic model_step(int k, logic s, logic a, logic v);
    int nph;
    nph = m_phase[k];
    if (a) begin
      nph = 0; m_taken[k] = 0; m_drained[k] = 0;
    end else begin
      case (m_phase[k])
        0: if (s) begin nph = 1; m_taken[k] = 0; end
        1: if (v) begin
             m_taken[k]++;
             if (m_taken[k] == NP[k]) begin
               m_taken[k] = 0; m_drained[k] = 0;
               nph = (PL[k] > 0) ? 2 : 3;
             end
           end
        2: begin
             m_drained[k]++;
             if (m_drained[k] == PL[k]) nph = 3;
           end
        default: if (!s) nph = 0;
                 else if (CT[k] != 0) begin nph = 1; m_taken[k] = 0; end
      endcase
    end
    m_pulse[k] = (nph == 3) && (m_phase[k] != 3);
    m_phase[k] = nph;
  endtask

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, a, e);
    end
  endtask

  // Apply inputs mid-cycle, check all instances, then advance one clock.
  task automatic cycle(input logic s, input logic a, input logic v);
    strt_cmpt = s; abort = a; in_vld = v;
    #1;
    for (int k = 0; k < 3; k++) begin
      smp[k] = act[k];
      check($sformatf("model inst%0d t%0d", k, cyc), 32'(act[k]), 32'(m_exp(k, a, v)));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, s, a, v);
    cyc++;
    #1;
  endtask

  task automatic idle_all();
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic       s, a, v;
    logic [1:0] st;
    logic [3:0] idx;
    logic       ld, acc, ov, bz;
  } vec_t;
  vec_t tbl [13];

  initial begin
    int n_ld, first_ov, ov_cnt, idle_seen;
    int ov_q [$];

    tbl[0]  = '{1, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 2'd1, 4'd0, 1, 1, 0, 1};
    tbl[2]  = '{0, 0, 1, 2'd1, 4'd1, 1, 0, 0, 1};
    tbl[3]  = '{0, 0, 1, 2'd1, 4'd2, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 1, 2'd1, 4'd3, 1, 0, 0, 1};
    tbl[5]  = '{0, 0, 1, 2'd1, 4'd4, 1, 0, 0, 1};
    tbl[6]  = '{0, 0, 1, 2'd1, 4'd5, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 2'd1, 4'd6, 1, 0, 0, 1};
    tbl[8]  = '{0, 0, 1, 2'd1, 4'd7, 1, 0, 0, 1};
    tbl[9]  = '{0, 0, 1, 2'd2, 4'd0, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 1, 2'd2, 4'd0, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 2'd3, 4'd0, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0};

    strt_cmpt = 1'b0; abort = 1'b0; in_vld = 1'b0;
    rst = 1'b0;
    model_reset();
    #13;
    for (int k = 0; k < 3; k++) check($sformatf("reset outputs inst%0d", k), 32'(act[k]), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Nominal transform, default configuration
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].s, tbl[i].a, tbl[i].v);
      check($sformatf("table row%0d", i),
            32'({smp[0][1:0], smp[0][8:5], smp[0][10], smp[0][9], smp[0][3], smp[0][4]}),
            32'({tbl[i].st, tbl[i].idx, tbl[i].ld, tbl[i].acc, tbl[i].ov, tbl[i].bz}));
    end

    // Stalls on cycles 3 and 6
    idle_all();
    n_ld = 0; first_ov = -1;
    for (int c = 0; c < 15; c++) begin
      cycle(c == 0, 1'b0, !(c == 3 || c == 6));
      if (c == 3) check("stall idx at c3", 32'(smp[0][8:5]), 32'd2);
      if (c == 6) check("stall idx at c6", 32'(smp[0][8:5]), 32'd4);
      if (smp[0][10]) n_ld++;
      if (smp[0][3] && first_ov < 0) first_ov = c;
    end
    check("stall load_en count", 32'(n_ld), 32'd8);
    check("stall out_vld cycle", 32'(first_ov), 32'd13);

    // N_PTS=16, PIPE_LAT=0, start held high
    idle_all();
    first_ov = -1; ov_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (smp[2][3]) begin ov_cnt++; if (first_ov < 0) first_ov = c; end
    end
    check("n16 out_vld cycle", 32'(first_ov), 32'd17);
    check("n16 out_vld pulses", 32'(ov_cnt), 32'd1);
    check("n16 done held", 32'(smp[2][1:0]), 32'd3);
    cycle(1'b0, 1'b0, 1'b1);
    check("n16 done before drop", 32'(smp[2][1:0]), 32'd3);
    cycle(1'b0, 1'b0, 1'b0);
    check("n16 idle after drop", 32'(smp[2][1:0]), 32'd0);

    // Continuous mode back-to-back
    idle_all();
    idle_seen = 0;
    for (int c = 0; c < 35; c++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (smp[1][3]) ov_q.push_back(c);
      if (c >= 1 && c <= 33 && smp[1][1:0] == 2'd0) idle_seen++;
    end
    check("cont pulse count", 32'(ov_q.size()), 32'd3);
    if (ov_q.size() == 3) begin
      check("cont pulse 1", 32'(ov_q[0]), 32'd11);
      check("cont pulse 2", 32'(ov_q[1]), 32'd22);
      check("cont pulse 3", 32'(ov_q[2]), 32'd33);
    end
    check("cont no idle", 32'(idle_seen), 32'd0);

    // Abort at sample 5, then abort with the final sample
    idle_all();
    for (int c = 0; c < 6; c++) cycle(c == 0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("abort5 idx", 32'(smp[0][8:5]), 32'd5);
    check("abort5 load_en", 32'(smp[0][10]), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    check("abort5 idle", 32'(smp[0][1:0]), 32'd0);
    for (int c = 0; c < 8; c++) cycle(c == 0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("abort7 idx", 32'(smp[0][8:5]), 32'd7);
    check("abort7 load_en", 32'(smp[0][10]), 32'd0);
    ov_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (c == 0) check("abort7 idle", 32'(smp[0][1:0]), 32'd0);
      if (smp[0][3]) ov_cnt++;
    end
    check("abort7 no out_vld", 32'(ov_cnt), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("abort+start stays idle", 32'(smp[0][1:0]), 32'd0);

    // Asynchronous reset mid-DRAIN
    idle_all();
    for (int c = 0; c < 10; c++) cycle(c == 0, 1'b0, 1'b1);
    check("pre-rst drain", 32'(smp[0][1:0]), 32'd2);
    #2; rst = 1'b0; model_reset();
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("async rst inst%0d", k), 32'(act[k]), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    first_ov = -1;
    for (int c = 0; c < 13; c++) begin
      cycle(c == 0, 1'b0, 1'b1);
      if (smp[0][3] && first_ov < 0) first_ov = c;
    end
    check("post-rst out_vld cycle", 32'(first_ov), 32'd11);

    // Random traffic against the model
    idle_all();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ff256_ct_seq_ctrl_param.md
# ff256_ct_seq_ctrl_param

Parametrised control FSM for the sequential FF(256) cosine-transform datapath. It sequences N_PTS input samples into the multiply-accumulate array, then waits PIPE_LAT drain cycles, then signals completion. It adds four things to the fixed 8-point controller:

- an input-valid stall during loading;
- a per-sample index output;
- a synchronous abort;
- an optional back-to-back (continuous) mode.

It sits beside the ff256_mult_by_const datapath and drives its enables.

## Interface
Parameters:
- N_PTS, 8, number of input samples per transform (≥2).
- PIPE_LAT, 2, datapath drain cycles after the last sample (≥0).
- CONTINUOUS, 0, 1 = DONE may re-enter LOAD directly when strt_cmpt is high.
- Derived, not overridable: IDX_W = max(1, $clog2(N_PTS)), CNT_W = max(1, $clog2(max(N_PTS, PIPE_LAT))).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- strt_cmpt  in  1  start request, level.
- abort  in  1  synchronous abort, highest priority below rst.
- in_vld  in  1  current input sample x[sample_idx] is valid.
- load_en  out  1  datapath accumulates the current sample this cycle.
- acc_clr  out  1  first-sample marker: accumulators load instead of adding.
- sample_idx  out  IDX_W  index of the sample expected/consumed.
- busy  out  1  high in LOAD or DRAIN.
- out_vld  out  1  one-cycle pulse: X_out is valid.
- done  out  1  high while in DONE.
- state_o  out  2  IDLE=0, LOAD=1, DRAIN=2, DONE=3.

## Operation
- Registers: state (2b), cnt (CNT_W), out_vld_r.
- All other outputs decode combinationally from state/cnt:
  - load_en = (state==LOAD) & in_vld & ~abort.
  - acc_clr = load_en & (cnt==0).
  - sample_idx = cnt[IDX_W-1:0] in LOAD, else 0.
- IDLE:
  - strt_cmpt=1 → LOAD, cnt=0.
- LOAD:
  - Each cycle with in_vld=1: cnt+1.
  - in_vld=0: hold state and cnt (stall, no accumulate).
  - When in_vld=1 at cnt==N_PTS-1 and PIPE_LAT>0: → DRAIN, cnt=0.
  - Same condition with PIPE_LAT==0: → DONE.
- DRAIN:
  - cnt increments every cycle; in_vld is ignored.
  - At cnt==PIPE_LAT-1: → DONE.
- DONE:
  - strt_cmpt=0 → IDLE.
  - strt_cmpt=1 with CONTINUOUS=0 → stay in DONE (one transform per request; strt_cmpt must drop to rearm).
  - strt_cmpt=1 with CONTINUOUS=1 → LOAD, cnt=0.
- out_vld_r is set on the clock edge that enters DONE and cleared on the next edge. It therefore pulses once per DONE entry, including repeated back-to-back entries.
- abort=1 in any state: next state IDLE, cnt=0, out_vld_r=0; load_en forced 0 that cycle.
- Illegal or unknown state: → IDLE.
- strt_cmpt is ignored in LOAD and DRAIN.

## Timing
- Reset (rst=0): state=IDLE, cnt=0, out_vld_r=0. Outputs during reset: load_en=0, acc_clr=0, sample_idx=0, busy=0, out_vld=0, done=0, state_o=0.
- Latency, no stalls: strt_cmpt sampled at edge 0; LOAD occupies cycles 1..N_PTS; DRAIN occupies the next PIPE_LAT cycles; out_vld and done rise at cycle N_PTS+PIPE_LAT+1. Defaults: 10 busy cycles, done at cycle 11.
- Each in_vld=0 cycle in LOAD adds exactly one cycle.
- Minimum period:
  - CONTINUOUS=1: N_PTS+PIPE_LAT+1 cycles.
  - CONTINUOUS=0: N_PTS+PIPE_LAT+2 cycles (the DONE→IDLE cycle is extra).
- Simultaneous events:
  - abort with the final in_vld → IDLE; no DRAIN, no out_vld.
  - abort with strt_cmpt in IDLE → stay IDLE.
- rst mid-operation: immediate asynchronous return to IDLE. The partial transform is discarded.

## Test plan
- Defaults, in_vld=1, strt_cmpt pulsed 1 cycle:
  - sample_idx 0..7 on cycles 1–8, acc_clr only on cycle 1.
  - busy for 10 cycles; out_vld single pulse at cycle 11.
  - DONE→IDLE at cycle 12.
- Defaults, in_vld low on cycles 3 and 6:
  - sample_idx holds at 2 and at 4 respectively (two stall cycles, idx 0..7 still consumed in order).
  - load_en count is exactly 8.
  - out_vld at cycle 13.
- N_PTS=16, PIPE_LAT=0, strt_cmpt held high, CONTINUOUS=0:
  - out_vld at cycle 17.
  - DONE persists while strt_cmpt stays high.
  - Drop strt_cmpt → IDLE next cycle.
- CONTINUOUS=1, defaults, strt_cmpt held high for 3 transforms: out_vld pulses at cycles 11, 22, 33; never in IDLE between them.
- abort at sample_idx=5, then again on the cycle the final sample is valid:
  - IDLE next cycle each time; no out_vld; load_en=0 on the abort cycle.
- rst asserted asynchronously mid-DRAIN: all outputs return to reset values immediately; a new start after rst release runs a full transform.
